// File: rtl/clfifo_word_unpacker_pkg.sv
// Shared types and widths for the cache-line to word unpacker.
// Line/word widths match the clfifo read and wordfifo write ports.
package clfifo_word_unpacker_pkg;

  localparam int LINE_W         = 512;
  localparam int WORD_W         = 32;
  localparam int COUNT_W        = 32;
  localparam int WORDS_PER_LINE = LINE_W / WORD_W;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EMIT,
    DONE
  } t_unpack_state;

endpackage

// File: rtl/clfifo_word_unpacker.sv
// Pops cache lines from a show-ahead clfifo and writes them as words.
// Ports: start/num_words/busy/done control, cl_re_* pop, word_* write.
module clfifo_word_unpacker
  import clfifo_word_unpacker_pkg::*;
#(
  parameter int WORD_WIDTH  = WORD_W,
  parameter int LINE_WIDTH  = LINE_W,
  parameter int COUNT_WIDTH = COUNT_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] num_words,
  output logic                   busy,
  output logic                   done,
  input  logic [LINE_WIDTH-1:0]  cl_re_tdata,
  input  logic                   cl_re_tvalid,
  output logic                   cl_re_tready,
  output logic                   word_we,
  output logic [WORD_WIDTH-1:0]  word_wdata,
  input  logic                   word_almostfull
);

  localparam int WPL   = LINE_WIDTH / WORD_WIDTH;
  localparam int IDX_W = $clog2(WPL);

  t_unpack_state state_q;

  logic [COUNT_WIDTH-1:0]          remaining_q;
  logic [IDX_W-1:0]                idx_q;
  logic [WPL-1:0][WORD_WIDTH-1:0]  line_q;
  logic                            word_we_q;
  logic [WORD_WIDTH-1:0]           word_wdata_q;

  logic emit;
  logic last_word;
  logic end_line;
  logic reload;
  logic pop;

  always_comb begin
    emit      = (state_q == EMIT) && !word_almostfull;
    last_word = (remaining_q == COUNT_WIDTH'(1));
    end_line  = (idx_q == IDX_W'(WPL - 1));
    // Pop the next line in the same cycle as the last word of this one.
    reload    = emit && end_line &&
                (remaining_q > COUNT_WIDTH'(1));
    cl_re_tready = (state_q == LOAD) || reload;
    pop       = cl_re_tvalid && cl_re_tready;
  end

  // Line register carries data only; it needs no reset.
  always_ff @(posedge clk) begin
    if (pop) line_q <= cl_re_tdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      idx_q        <= '0;
      word_we_q    <= 1'b0;
      word_wdata_q <= '0;
    end else begin
      word_we_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (num_words != '0) begin
              remaining_q <= num_words;
              state_q     <= LOAD;
            end else begin
              state_q <= DONE;
            end
          end
        end
        LOAD: begin
          if (cl_re_tvalid) begin
            idx_q   <= '0;
            state_q <= EMIT;
          end
        end
        EMIT: begin
          if (emit) begin
            word_we_q    <= 1'b1;
            word_wdata_q <= line_q[idx_q];
            remaining_q  <= remaining_q - COUNT_WIDTH'(1);
            idx_q        <= idx_q + IDX_W'(1);
            if (last_word) begin
              state_q <= DONE;
            end else if (end_line) begin
              if (cl_re_tvalid) idx_q <= '0;
              else              state_q <= LOAD;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign word_we    = word_we_q;
  assign word_wdata = word_wdata_q;

endmodule

// File: tb/tb_clfifo_word_unpacker.sv
// Directed scoreboard bench for clfifo_word_unpacker.
// Models a show-ahead clfifo and checks every word written.
module tb_clfifo_word_unpacker;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [31:0]  num_words;
  logic         busy;
  logic         done;
  logic [511:0] cl_re_tdata;
  logic         cl_re_tvalid;
  logic         cl_re_tready;
  logic         word_we;
  logic [31:0]  word_wdata;
  logic         word_almostfull;

  clfifo_word_unpacker dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .num_words       (num_words),
    .busy            (busy),
    .done            (done),
    .cl_re_tdata     (cl_re_tdata),
    .cl_re_tvalid    (cl_re_tvalid),
    .cl_re_tready    (cl_re_tready),
    .word_we         (word_we),
    .word_wdata      (word_wdata),
    .word_almostfull (word_almostfull)
  );

  always #5 clk = ~clk;

  logic [511:0] lines [16];
  int line_wr = 0;
  int line_rd = 0;

  assign cl_re_tvalid = (line_rd < line_wr);
  assign cl_re_tdata  = lines[line_rd % 16];

  always @(posedge clk) begin
    if (cl_re_tvalid && cl_re_tready) line_rd <= line_rd + 1;
  end

  logic [31:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;
  int rdy_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    if (word_we === 1'b1) begin
      wr_cnt++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
      n_tests++;
      assert (word_wdata === e) else begin
        n_fail++;
        $error("FAIL word: observed %0h expected %0h", word_wdata, e);
      end
    end
    if (cl_re_tready === 1'b1) rdy_cnt++;
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic push_line(input logic [31:0] base);
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = base + 32'(i);
    lines[line_wr % 16] = l;
    line_wr++;
  endtask

  task automatic expect_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(i));
  endtask

  task automatic do_start(input logic [31:0] n);
    start     = 1'b1;
    num_words = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_word(input logic [31:0] val, input string tag);
    bit got = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (word_we === 1'b1 && word_wdata === val) begin
        got = 1;
        break;
      end
    end
    check(tag, 64'(got), 64'd1);
  endtask

  task automatic wait_done(input int nw, input bit span,
                           input int wr0, input string tag);
    bit got = 0;
    int first = -1;
    int k;
    for (k = 0; k < 300; k++) begin
      tick();
      if (word_we === 1'b1 && first < 0) first = k;
      if (done === 1'b1) begin
        got = 1;
        break;
      end
    end
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    if (got) begin
      check({tag, "_we_at_done"}, 64'(word_we), 64'd1);
      if (span) check({tag, "_no_gap"}, 64'(k - first + 1), 64'(nw));
    end
    tick();
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_writes"}, 64'(wr_cnt - wr0), 64'(nw));
    check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  int wr0, pop0, dn0, rdy0, snap;

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    num_words = '0;
    word_almostfull = 1'b0;
    tick();
    tick();
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_done",  64'(done), 64'd0);
    check("rst_we",    64'(word_we), 64'd0);
    check("rst_wdata", 64'(word_wdata), 64'd0);
    check("rst_ready", 64'(cl_re_tready), 64'd0);
    reset_n = 1'b1;
    tick();

    // 1: one full line
    wr0 = wr_cnt; pop0 = line_rd; dn0 = done_cnt;
    push_line(32'h1000);
    expect_words(32'h1000, 16);
    do_start(32'd16);
    wait_done(16, 1'b1, wr0, "t1");
    check("t1_pops", 64'(line_rd - pop0), 64'd1);
    check("t1_done_cnt", 64'(done_cnt - dn0), 64'd1);

    // 2: 40 words over three preloaded lines
    wr0 = wr_cnt; pop0 = line_rd; dn0 = done_cnt;
    push_line(32'h2000);
    push_line(32'h2100);
    push_line(32'h2200);
    expect_words(32'h2000, 16);
    expect_words(32'h2100, 16);
    expect_words(32'h2200, 8);
    do_start(32'd40);
    wait_done(40, 1'b1, wr0, "t2");
    check("t2_pops", 64'(line_rd - pop0), 64'd3);
    check("t2_done_cnt", 64'(done_cnt - dn0), 64'd1);

    // 3: almostfull stall after word 6
    wr0 = wr_cnt;
    push_line(32'h3000);
    expect_words(32'h3000, 16);
    do_start(32'd16);
    wait_word(32'h3006, "t3_w6");
    word_almostfull = 1'b1;
    tick();
    snap = wr_cnt;
    repeat (4) tick();
    check("t3_stall", 64'(wr_cnt), 64'(snap));
    word_almostfull = 1'b0;
    wait_done(16, 1'b0, wr0, "t3");

    // 4: second line arrives late
    wr0 = wr_cnt; pop0 = line_rd;
    push_line(32'h4000);
    expect_words(32'h4000, 16);
    expect_words(32'h5000, 16);
    do_start(32'd32);
    wait_word(32'h400F, "t4_w15");
    repeat (3) tick();
    check("t4_ready", 64'(cl_re_tready), 64'd1);
    check("t4_busy", 64'(busy), 64'd1);
    check("t4_held", 64'(wr_cnt - wr0), 64'd16);
    repeat (7) tick();
    push_line(32'h5000);
    wait_done(32, 1'b0, wr0, "t4");
    check("t4_pops", 64'(line_rd - pop0), 64'd2);

    // 5: zero-length transfer
    wr0 = wr_cnt; pop0 = line_rd; rdy0 = rdy_cnt;
    do_start(32'd0);
    check("t5_done", 64'(done), 64'd1);
    tick();
    check("t5_done_pulse", 64'(done), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_ready", 64'(rdy_cnt - rdy0), 64'd0);
    check("t5_writes", 64'(wr_cnt - wr0), 64'd0);
    check("t5_pops", 64'(line_rd - pop0), 64'd0);

    // 6: reset mid-line, then restart; extra start is ignored
    push_line(32'h6000);
    expect_words(32'h6000, 16);
    do_start(32'd16);
    wait_word(32'h6005, "t6_w5");
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_busy",  64'(busy), 64'd0);
    check("t6_rst_done",  64'(done), 64'd0);
    check("t6_rst_we",    64'(word_we), 64'd0);
    check("t6_rst_wdata", 64'(word_wdata), 64'd0);
    check("t6_rst_ready", 64'(cl_re_tready), 64'd0);
    exp_q.delete();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    wr0 = wr_cnt; dn0 = done_cnt;
    push_line(32'h7000);
    expect_words(32'h7000, 16);
    do_start(32'd16);
    repeat (3) tick();
    check("t6_busy", 64'(busy), 64'd1);
    do_start(32'd5);
    wait_done(16, 1'b0, wr0, "t6");
    repeat (5) tick();
    check("t6_done_cnt", 64'(done_cnt - dn0), 64'd1);
    check("t6_no_extra", 64'(wr_cnt - wr0), 64'd16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
